cache_refill_ctrl: RTL
======================

// Module: cache_refill_ctrl
// PURPOSE
// Sequences the set-associative cache for two requesters: instruction fetch (port 0) and data (port 1).
// Arbitrates between them round-robin and issues a tag lookup.
// On a miss it invalidates the victim way, burst-reads the line from RAM and writes it beat by beat.
// It then validates the tag and returns the requested word.
// Sits between the core's fetch/LSU front ends, the cache tag/data stores and the RAM port.
// PARAMETERS
// WORD_WID  64  bits per word/beat
// BEATS     4   words per line (power of 2, >=2)
// IDX_WID   3   set index width
// WAY_WID   2   way index width
// PORTS
// clk_i         in   1          clock, all state on posedge
// rst_ni        in   1          reset, asynchronous, active-low
// req0_valid_i  in   1          fetch request valid
// req0_addr_i   in   32         fetch byte address
// req0_ready_o  out  1          fetch request accepted this cycle
// req1_valid_i  in   1          data request valid
// req1_addr_i   in   32         data byte address
// req1_ready_o  out  1          data request accepted this cycle
// lk_valid_o    out  1          lookup strobe to tag store
// lk_addr_o     out  32         lookup address (captured request address)
// lk_hit_i      in   1          hit, valid the cycle after lk_valid_o
// lk_data_i     in   WORD_WID   hit word, same timing as lk_hit_i
// victim_way_i  in   WAY_WID    replacement way, same timing as lk_hit_i
// mem_req_o     out  1          RAM burst request, held until granted
// mem_addr_o    out  32         line-aligned burst address
// mem_gnt_i     in   1          RAM accepted burst
// mem_rvalid_i  in   1          RAM read beat valid
// mem_rdata_i   in   WORD_WID   RAM read beat data
// fill_we_o     out  1          data-store write strobe
// fill_way_o    out  WAY_WID    way being filled/tagged
// fill_beat_o   out  log2(BEATS) beat index within line
// fill_data_o   out  WORD_WID   write data (= mem_rdata_i)
// tag_we_o      out  1          tag write strobe (set = lk_addr_o index, way = fill_way_o)
// tag_valid_o   out  1          valid bit written with the tag
// resp_valid_o  out  1          one-cycle response pulse
// resp_id_o     out  1          requester of response (0 fetch, 1 data)
// resp_data_o   out  WORD_WID   requested word
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; last_grant=1 (port 0 wins first tie); beat counter 0.
// - Word offset = addr[log2(WORD_WID/8)+:log2(BEATS)]. Line address = addr with low log2(BEATS*WORD_WID/8) bits cleared.
// - IDLE: ready_o is combinational, high only to the granted valid port. Tie goes to the port != last_grant.
//   On accept: latch addr and id, update last_grant, go to LOOKUP.
// - LOOKUP: lk_valid_o=1 for exactly one cycle, then CHECK.
// - CHECK: sample lk_hit_i.
//   - Hit: register lk_data_i, go to RESP.
//   - Miss: latch victim_way_i into fill_way_o, go to INVAL.
// - INVAL: tag_we_o=1, tag_valid_o=0 for one cycle, so the victim is never valid with partial data. Then MISS_REQ.
// - MISS_REQ: mem_req_o=1 with the line address until mem_gnt_i is sampled high, then FILL.
// - FILL: each mem_rvalid_i cycle gives fill_we_o=1 with fill_beat_o=counter, and the counter increments.
//   The beat whose index equals the word offset is captured as the response word.
//   The last beat (counter=BEATS-1) goes to UPDATE; the counter wraps to 0. No rvalid means wait.
// - UPDATE: tag_we_o=1, tag_valid_o=1 for one cycle, then RESP.
// - RESP: resp_valid_o=1 for one cycle with the latched id and word, then IDLE.
// - Latency from accept cycle 0: hit pulses resp_valid_o at cycle 3.
//   Miss with gnt on its first cycle and back-to-back beats: resp at cycle 6+BEATS.
// - mem_rvalid_i outside FILL is ignored. mem_gnt_i outside MISS_REQ is ignored. ready_o is low outside IDLE.
// - Reset mid-operation: return to IDLE immediately with no further strobes. The victim stays invalid from INVAL.
// TESTING
// - Reset, then only req0 valid, addr 0x100, hit with lk_data_i=0xA5 -> ready0 at c0, lk_valid c1, resp c3 id0 data 0xA5.
// - Both valid every cycle, all hits -> grants alternate 0,1,0,1; never two readies in one cycle.
// - req1 addr 0x1018 miss, victim 2, rvalid 4 back-to-back -> mem_addr 0x1000, fill beats 0..3 way 2.
//   Order: tag_we valid=0 before the first fill, tag_we valid=1 after, resp data = beat 3.
// - Miss with gnt delayed 5 cycles and rvalid gaps of 2 -> mem_req held 5 cycles, exactly 4 fill_we, resp one cycle after UPDATE.
// - rst_ni low after beat 1 of a fill -> all outputs 0 asynchronously.
//   After release: IDLE, port 0 first, stray rvalid causes no fill_we.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// Bundles the requester, tag-store, RAM and response signals of the cache refill controller.
// The master modport is the controller's view; the slave modport is its environment's view.
interface cache_refill_ctrl_if #(
   parameter int WORD_WID = 64,
   parameter int BEATS    = 4,
   parameter int WAY_WID  = 2
);
   localparam int BEAT_WID = $clog2(BEATS);

   logic                req0_valid_i;
   logic [31:0]         req0_addr_i;
   logic                req0_ready_o;
   logic                req1_valid_i;
   logic [31:0]         req1_addr_i;
   logic                req1_ready_o;
   logic                lk_valid_o;
   logic [31:0]         lk_addr_o;
   logic                lk_hit_i;
   logic [WORD_WID-1:0] lk_data_i;
   logic [WAY_WID-1:0]  victim_way_i;
   logic                mem_req_o;
   logic [31:0]         mem_addr_o;
   logic                mem_gnt_i;
   logic                mem_rvalid_i;
   logic [WORD_WID-1:0] mem_rdata_i;
   logic                fill_we_o;
   logic [WAY_WID-1:0]  fill_way_o;
   logic [BEAT_WID-1:0] fill_beat_o;
   logic [WORD_WID-1:0] fill_data_o;
   logic                tag_we_o;
   logic                tag_valid_o;
   logic                resp_valid_o;
   logic                resp_id_o;
   logic [WORD_WID-1:0] resp_data_o;

   modport master (
      input  req0_valid_i, req0_addr_i, req1_valid_i, req1_addr_i,
      input  lk_hit_i, lk_data_i, victim_way_i,
      input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      output req0_ready_o, req1_ready_o, lk_valid_o, lk_addr_o,
      output mem_req_o, mem_addr_o,
      output fill_we_o, fill_way_o, fill_beat_o, fill_data_o,
      output tag_we_o, tag_valid_o,
      output resp_valid_o, resp_id_o, resp_data_o
   );

   modport slave (
      output req0_valid_i, req0_addr_i, req1_valid_i, req1_addr_i,
      output lk_hit_i, lk_data_i, victim_way_i,
      output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
      input  req0_ready_o, req1_ready_o, lk_valid_o, lk_addr_o,
      input  mem_req_o, mem_addr_o,
      input  fill_we_o, fill_way_o, fill_beat_o, fill_data_o,
      input  tag_we_o, tag_valid_o,
      input  resp_valid_o, resp_id_o, resp_data_o
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Round-robin front end for fetch/data requesters: tag lookup, and on a miss victim
// invalidation, line burst refill, tag validation and return of the requested word.
module cache_refill_ctrl #(
   parameter int WORD_WID = 64,
   parameter int BEATS    = 4,
   parameter int IDX_WID  = 3,
   parameter int WAY_WID  = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   cache_refill_ctrl_if.master bus
);
   localparam int BEAT_WID = $clog2(BEATS);
   localparam int BYTE_OFF = $clog2(WORD_WID / 8);
   localparam int LINE_OFF = BYTE_OFF + BEAT_WID;

   if (LINE_OFF + IDX_WID > 32) begin : g_addr_chk
      $error("cache_refill_ctrl: offset plus index exceed the 32-bit address");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_CHECK, S_INVAL, S_MISS_REQ, S_FILL, S_UPDATE, S_RESP
   } state_e;

   state_e              state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic                id_q, id_d;
   logic                last_q, last_d;
   logic [WAY_WID-1:0]  way_q, way_d;
   logic [BEAT_WID-1:0] cnt_q, cnt_d;
   logic [WORD_WID-1:0] word_q, word_d;
   logic                grant0, grant1;
   logic [BEAT_WID-1:0] word_off;

   // A tie goes to the port that did not win last time.
   assign grant0   = bus.req0_valid_i & (~bus.req1_valid_i | last_q);
   assign grant1   = bus.req1_valid_i & (~bus.req0_valid_i | ~last_q);
   assign word_off = addr_q[BYTE_OFF +: BEAT_WID];

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      id_d    = id_q;
      last_d  = last_q;
      way_d   = way_q;
      cnt_d   = cnt_q;
      word_d  = word_q;

      bus.req0_ready_o = 1'b0;
      bus.req1_ready_o = 1'b0;
      bus.lk_valid_o   = 1'b0;
      bus.lk_addr_o    = addr_q;
      bus.mem_req_o    = 1'b0;
      bus.mem_addr_o   = {addr_q[31:LINE_OFF], {LINE_OFF{1'b0}}};
      bus.fill_we_o    = 1'b0;
      bus.fill_way_o   = way_q;
      bus.fill_beat_o  = cnt_q;
      bus.fill_data_o  = '0;
      bus.tag_we_o     = 1'b0;
      bus.tag_valid_o  = 1'b0;
      bus.resp_valid_o = 1'b0;
      bus.resp_id_o    = id_q;
      bus.resp_data_o  = word_q;

      case (state_q)
         S_IDLE: begin
            // Readies are qualified by reset so every output is low while it is held.
            bus.req0_ready_o = grant0 & rst_ni;
            bus.req1_ready_o = grant1 & rst_ni;
            if (grant0 || grant1) begin
               addr_d  = grant1 ? bus.req1_addr_i : bus.req0_addr_i;
               id_d    = grant1;
               last_d  = grant1;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            bus.lk_valid_o = 1'b1;
            state_d        = S_CHECK;
         end
         S_CHECK: begin
            if (bus.lk_hit_i) begin
               word_d  = bus.lk_data_i;
               state_d = S_RESP;
            end else begin
               way_d   = bus.victim_way_i;
               state_d = S_INVAL;
            end
         end
         S_INVAL: begin
            // Victim is invalidated before any beat lands so it never looks valid half-filled.
            bus.tag_we_o    = 1'b1;
            bus.tag_valid_o = 1'b0;
            state_d         = S_MISS_REQ;
         end
         S_MISS_REQ: begin
            bus.mem_req_o = 1'b1;
            if (bus.mem_gnt_i) state_d = S_FILL;
         end
         S_FILL: begin
            if (bus.mem_rvalid_i) begin
               bus.fill_we_o   = 1'b1;
               bus.fill_data_o = bus.mem_rdata_i;
               cnt_d           = cnt_q + 1'b1;
               if (cnt_q == word_off) word_d = bus.mem_rdata_i;
               if (cnt_q == BEAT_WID'(BEATS - 1)) state_d = S_UPDATE;
            end
         end
         S_UPDATE: begin
            bus.tag_we_o    = 1'b1;
            bus.tag_valid_o = 1'b1;
            state_d         = S_RESP;
         end
         S_RESP: begin
            bus.resp_valid_o = 1'b1;
            state_d          = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         way_q   <= '0;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         id_q    <= id_d;
         last_q  <= last_d;
         way_q   <= way_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end
endmodule
